// File: rtl/mdu_iter.sv
// Iterative RV M-extension multiply/divide unit: shift-add multiplier, radix-2 restoring
// divider, zero-latency divide corner cases and a single-entry quotient/remainder cache.
module mdu_iter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);
  localparam int unsigned MUL_ITERS = XLEN / MUL_STEP;
  localparam int unsigned CNT_W     = $clog2(XLEN);
  localparam int unsigned SUM_W     = XLEN + MUL_STEP;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

  state_t state, state_next;
  logic   ready_next, busy_next;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_funct;
  logic             op_neg_q, op_neg_r, op_sgn;
  logic [XLEN-1:0]  op_rs1, op_rs2;
  // hi/lo: product accumulator while multiplying, remainder/quotient while dividing
  logic [XLEN-1:0]  opa, opb, hi, lo;

  logic             cache_valid, cache_sgn;
  logic [XLEN-1:0]  cache_rs1, cache_rs2, cache_q, cache_r;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
    return (sgn && x[XLEN-1]) ? -x : x;
  endfunction

  // Request decode and zero-latency divide results
  logic            div_sgn, mul_a_sgn, mul_b_sgn;
  logic            div_zero, div_ovf, cache_hit, fast;
  logic [XLEN-1:0] fast_q, fast_r;

  always_comb begin
    div_sgn   = !req_funct[0];
    mul_a_sgn = (req_funct == 3'd1) || (req_funct == 3'd2);
    mul_b_sgn = (req_funct == 3'd1);
    div_zero  = (req_rs2 == '0);
    div_ovf   = div_sgn && (req_rs1 == MOST_NEG) && (req_rs2 == '1);
    cache_hit = cache_valid && (cache_rs1 == req_rs1) && (cache_rs2 == req_rs2)
                && (cache_sgn == div_sgn);
    fast      = req_funct[2] && (div_zero || div_ovf || cache_hit);
    fast_q    = cache_q;
    fast_r    = cache_r;
    if (div_zero) begin
      fast_q = '1;
      fast_r = req_rs1;
    end else if (div_ovf) begin
      fast_q = req_rs1;
      fast_r = '0;
    end
  end

  // One multiply step (MUL_STEP multiplier bits) and one restoring-divide step
  logic [SUM_W-1:0]  mul_sum;
  logic [XLEN-1:0]   mul_hi_nx, mul_lo_nx, mul_res;
  logic [2*XLEN-1:0] prod, prod_fin;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_r_nx, div_q_nx, q_fin, r_fin;
  logic              last_iter;

  always_comb begin
    mul_sum   = SUM_W'(hi) + SUM_W'(opa) * SUM_W'(opb[MUL_STEP-1:0]);
    mul_hi_nx = mul_sum[SUM_W-1:MUL_STEP];
    mul_lo_nx = {mul_sum[MUL_STEP-1:0], lo[XLEN-1:MUL_STEP]};
    prod      = {mul_hi_nx, mul_lo_nx};
    prod_fin  = op_neg_q ? -prod : prod;
    mul_res   = (op_funct == 3'd0) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
    div_shift = {hi, lo[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opa});
    div_r_nx  = div_ge ? (div_shift[XLEN-1:0] - opa) : div_shift[XLEN-1:0];
    div_q_nx  = {lo[XLEN-2:0], div_ge};
    q_fin     = op_neg_q ? -div_q_nx : div_q_nx;
    r_fin     = op_neg_r ? -div_r_nx : div_r_nx;
    last_iter = (state == ST_MUL) ? (cnt == CNT_W'(MUL_ITERS - 1)) : (cnt == CNT_W'(XLEN - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      req_ready <= ready_next;
      busy      <= busy_next;
    end
  end

  // The pulse in DONE is gated by flush so a same-cycle flush kills it
  always_comb begin
    state_next = state;
    resp_valid = (state == ST_DONE) && !flush;
    case (state)
      ST_IDLE: if (req_valid) state_next = fast ? ST_DONE : (req_funct[2] ? ST_DIV : ST_MUL);
      ST_MUL:  if (last_iter) state_next = ST_DONE;
      ST_DIV:  if (last_iter) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
    ready_next = (state_next == ST_IDLE);
    busy_next  = !ready_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      op_funct    <= '0;
      op_neg_q    <= 1'b0;
      op_neg_r    <= 1'b0;
      op_sgn      <= 1'b0;
      op_rs1      <= '0;
      op_rs2      <= '0;
      opa         <= '0;
      opb         <= '0;
      hi          <= '0;
      lo          <= '0;
      resp_data   <= '0;
      cache_valid <= 1'b0;
      cache_sgn   <= 1'b0;
      cache_rs1   <= '0;
      cache_rs2   <= '0;
      cache_q     <= '0;
      cache_r     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req_valid && !flush) begin
          cnt      <= '0;
          op_funct <= req_funct;
          op_rs1   <= req_rs1;
          op_rs2   <= req_rs2;
          op_sgn   <= div_sgn;
          if (fast) begin
            lo        <= fast_q;
            hi        <= fast_r;
            resp_data <= req_funct[1] ? fast_r : fast_q;
          end else if (req_funct[2]) begin
            opa      <= mag(req_rs2, div_sgn);
            lo       <= mag(req_rs1, div_sgn);
            hi       <= '0;
            op_neg_q <= div_sgn && (req_rs1[XLEN-1] ^ req_rs2[XLEN-1]);
            op_neg_r <= div_sgn && req_rs1[XLEN-1];
          end else begin
            opa      <= mag(req_rs1, mul_a_sgn);
            opb      <= mag(req_rs2, mul_b_sgn);
            hi       <= '0;
            lo       <= '0;
            op_neg_q <= (mul_a_sgn && req_rs1[XLEN-1]) ^ (mul_b_sgn && req_rs2[XLEN-1]);
          end
        end
        ST_MUL: begin
          cnt <= cnt + CNT_W'(1);
          hi  <= mul_hi_nx;
          lo  <= mul_lo_nx;
          opb <= opb >> MUL_STEP;
          if (state_next == ST_DONE) resp_data <= mul_res;
        end
        ST_DIV: begin
          cnt <= cnt + CNT_W'(1);
          if (last_iter) begin
            lo <= q_fin;
            hi <= r_fin;
          end else begin
            lo <= div_q_nx;
            hi <= div_r_nx;
          end
          if (state_next == ST_DONE) resp_data <= op_funct[1] ? r_fin : q_fin;
        end
        ST_DONE: if (!flush && op_funct[2]) begin
          cache_valid <= 1'b1;
          cache_sgn   <= op_sgn;
          cache_rs1   <= op_rs1;
          cache_rs2   <= op_rs2;
          cache_q     <= lo;
          cache_r     <= hi;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed XLEN=32 corner cases plus a random XLEN=64 sweep on two
// MUL_STEP variants checked against an arithmetic reference model.
module tb_mdu_iter;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst, flush;

  logic        v32, rdy32, rv32, busy32;
  logic [2:0]  f32;
  logic [31:0] a32, b32, rd32;

  logic        v64, rdy_a, rv_a, busy_a, rdy_b, rv_b, busy_b;
  logic [2:0]  f64;
  logic [63:0] a64, b64, rd_a, rd_b;

  int errors = 0;
  int checks = 0;

  bit          c_v = 1'b0;
  bit          c_s = 1'b0;
  logic [63:0] c_a = '0;
  logic [63:0] c_b = '0;

  always #5 clk = ~clk;

  mdu_iter #(.XLEN(32), .MUL_STEP(4)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(v32), .req_ready(rdy32),
    .req_funct(f32), .req_rs1(a32), .req_rs2(b32),
    .resp_valid(rv32), .resp_data(rd32), .busy(busy32));

  mdu_iter #(.XLEN(64), .MUL_STEP(1)) dut64_s1 (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(v64), .req_ready(rdy_a),
    .req_funct(f64), .req_rs1(a64), .req_rs2(b64),
    .resp_valid(rv_a), .resp_data(rd_a), .busy(busy_a));

  mdu_iter #(.XLEN(64), .MUL_STEP(8)) dut64_s8 (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(v64), .req_ready(rdy_b),
    .req_funct(f64), .req_rs1(a64), .req_rs2(b64),
    .resp_valid(rv_b), .resp_data(rd_b), .busy(busy_b));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {32'($urandom()), 32'($urandom())};
  endfunction

  // Exact RV M-extension result from wide arithmetic
  function automatic logic [63:0] ref_model(input logic [2:0] f, input logic [63:0] a,
                                            input logic [63:0] b);
    logic [127:0] ea, eb, p;
    longint       sa, sb;
    logic         ovf;
    sa  = longint'(a);
    sb  = longint'(b);
    ovf = (a == MIN64) && (b == '1);
    ea  = (f == 3'd1 || f == 3'd2) ? {{64{a[63]}}, a} : {64'd0, a};
    eb  = (f == 3'd1) ? {{64{b[63]}}, b} : {64'd0, b};
    p   = ea * eb;
    case (f)
      3'd0:    return p[63:0];
      3'd1,
      3'd2,
      3'd3:    return p[127:64];
      3'd4:    return (b == '0) ? '1 : (ovf ? a : 64'(sa / sb));
      3'd5:    return (b == '0) ? '1 : a / b;
      3'd6:    return (b == '0) ? a : (ovf ? 64'd0 : 64'(sa % sb));
      default: return (b == '0) ? a : a % b;
    endcase
  endfunction

  // Issue one XLEN=32 request from idle; check result and latency in cycles after acceptance
  task automatic op32(input string tag, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int          lat;
    logic [31:0] got;
    v32 = 1'b1; f32 = f; a32 = a; b32 = b;
    @(posedge clk); #1;
    v32 = 1'b0; a32 = $urandom(); b32 = $urandom();
    lat = 0; got = '0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (rv32) begin
        got = rd32;
        break;
      end
    end
    check($sformatf("%s latency", tag), 64'(lat), 64'(exp_lat));
    check($sformatf("%s data", tag), 64'(got), 64'(exp));
    @(posedge clk); #1;
  endtask

  // Issue one XLEN=64 request to both variants; expectations from model and cache tracker
  task automatic op64(input int idx, input logic [2:0] f, input logic [63:0] a,
                      input logic [63:0] b);
    logic [63:0] exp, da, db;
    bit          sgn, hit;
    int          la, lb, k, exp_la, exp_lb;
    exp    = ref_model(f, a, b);
    sgn    = !f[0];
    hit    = f[2] && ((b == '0) || (sgn && a == MIN64 && b == '1) ||
                      (c_v && c_a == a && c_b == b && c_s == sgn));
    exp_la = hit ? 1 : (f[2] ? 65 : 65);
    exp_lb = hit ? 1 : (f[2] ? 65 : 9);
    v64 = 1'b1; f64 = f; a64 = a; b64 = b;
    @(posedge clk); #1;
    v64 = 1'b0; a64 = rand64(); b64 = rand64();
    la = 0; lb = 0; k = 0; da = '0; db = '0;
    while ((la == 0 || lb == 0) && k < 200) begin
      @(negedge clk);
      k++;
      if (rv_a && la == 0) begin la = k; da = rd_a; end
      if (rv_b && lb == 0) begin lb = k; db = rd_b; end
    end
    check($sformatf("rnd%0d f%0d step1 latency", idx, f), 64'(la), 64'(exp_la));
    check($sformatf("rnd%0d f%0d step1 data", idx, f), da, exp);
    check($sformatf("rnd%0d f%0d step8 latency", idx, f), 64'(lb), 64'(exp_lb));
    check($sformatf("rnd%0d f%0d step8 data", idx, f), db, exp);
    if (f[2]) begin
      c_v = 1'b1; c_a = a; c_b = b; c_s = sgn;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int          k, pulses, first_k, second_k, acc_k;
    logic [31:0] d1, d2;
    logic [2:0]  rf;
    logic [63:0] ra, rb, pa, pb;

    rst = 1'b1; flush = 1'b0;
    v32 = 1'b0; f32 = '0; a32 = '0; b32 = '0;
    v64 = 1'b0; f64 = '0; a64 = '0; b64 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset req_ready", 64'(rdy32), 64'd1);
    check("reset resp_valid", 64'(rv32), 64'd0);
    check("reset resp_data", 64'(rd32), 64'd0);
    check("reset busy", 64'(busy32), 64'd0);
    check("reset x64 idle", 64'({rdy_a, rdy_b, busy_a, busy_b}), 64'b1100);
    @(posedge clk); #1;

    op32("MUL 7*-7", 3'd0, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFCF, 9);
    op32("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 9);
    op32("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 9);
    op32("MULHSU -1*max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9);

    op32("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    op32("REM -7/2 hit", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1);
    op32("REMU -7/2 miss", 3'd7, 32'hFFFF_FFF9, 32'd2, 32'd1, 33);
    op32("DIVU -7/2 hit", 3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1);

    op32("DIVU 5/0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    op32("REMU 5/0", 3'd7, 32'd5, 32'd0, 32'd5, 1);
    op32("DIV overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    op32("REM overflow", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Flush at divide iteration 10
    v32 = 1'b1; f32 = 3'd4; a32 = 32'd100; b32 = 32'd7;
    @(posedge clk); #1;
    v32 = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush req_ready", 64'(rdy32), 64'd1);
    check("flush busy", 64'(busy32), 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (rv32) pulses++;
    end
    check("flush no resp", 64'(pulses), 64'd0);
    @(posedge clk); #1;
    op32("REM 100/7 after flush", 3'd6, 32'd100, 32'd7, 32'd2, 33);

    // Request presented together with flush is dropped
    v32 = 1'b1; f32 = 3'd0; a32 = 32'd3; b32 = 32'd3; flush = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flushed req busy", 64'(busy32), 64'd0);
    check("flushed req resp", 64'(rv32), 64'd0);
    @(posedge clk); #1;

    // Flush during DONE kills the pulse and the cache write
    v32 = 1'b1; f32 = 3'd4; a32 = 32'd50; b32 = 32'd7;
    @(posedge clk); #1;
    v32 = 1'b0;
    repeat (32) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("done flush busy", 64'(busy32), 64'd1);
    check("done flush resp", 64'(rv32), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("done flush ready", 64'(rdy32), 64'd1);
    @(posedge clk); #1;
    op32("REM 50/7 after done flush", 3'd6, 32'd50, 32'd7, 32'd1, 33);

    // Reset mid-multiply clears outputs and the cache
    op32("DIV 20/6", 3'd4, 32'd20, 32'd6, 32'd3, 33);
    op32("REM 20/6 hit", 3'd6, 32'd20, 32'd6, 32'd2, 1);
    v32 = 1'b1; f32 = 3'd0; a32 = 32'd5; b32 = 32'd6;
    @(posedge clk); #1;
    v32 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst req_ready", 64'(rdy32), 64'd1);
    check("rst busy", 64'(busy32), 64'd0);
    check("rst resp_valid", 64'(rv32), 64'd0);
    check("rst resp_data", 64'(rd32), 64'd0);
    @(posedge clk); #1;
    op32("REM 20/6 after rst", 3'd6, 32'd20, 32'd6, 32'd2, 33);

    // Back-to-back with req_valid held; operands change right after the first acceptance
    v32 = 1'b1; f32 = 3'd0; a32 = 32'd3; b32 = 32'd5;
    @(posedge clk); #1;
    f32 = 3'd3; a32 = 32'hFFFF_FFFF; b32 = 32'd2;
    k = 0; first_k = 0; second_k = 0; acc_k = 0; d1 = '0; d2 = '0;
    while (k < 60 && second_k == 0) begin
      @(negedge clk);
      k++;
      if (rv32) begin
        if (first_k == 0) begin first_k = k; d1 = rd32; end
        else begin second_k = k; d2 = rd32; end
      end
      if (rdy32 && v32) begin
        acc_k = k;
        @(posedge clk); #1;
        v32 = 1'b0;
      end
    end
    v32 = 1'b0;
    check("b2b first latency", 64'(first_k), 64'd9);
    check("b2b first data", 64'(d1), 64'd15);
    check("b2b second accept", 64'(acc_k), 64'd10);
    check("b2b second latency", 64'(second_k), 64'd19);
    check("b2b second data", 64'(d2), 64'd1);
    @(posedge clk); #1;

    // Random XLEN=64 sweep; some picks reuse operands or hit the corner cases
    pa = rand64(); pb = rand64();
    for (int i = 0; i < 48; i++) begin
      rf = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0: begin ra = pa; rb = pb; end
        1: begin ra = rand64(); rb = '0; end
        2: begin ra = MIN64; rb = '1; end
        3: begin ra = 64'($urandom_range(0, 1000)); rb = 64'($urandom_range(1, 20)); end
        4: begin ra = -64'($urandom_range(0, 1000)); rb = 64'($urandom_range(1, 20)); end
        default: begin
          ra = rand64();
          rb = rand64() >> $urandom_range(0, 60);
        end
      endcase
      op64(i, rf, ra, rb);
      pa = ra; pb = rb;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
Parametrised iterative multiply/divide unit for the backend integer pipe. It executes the RV M-extension operations MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU on XLEN-bit operands. It uses a shift-add multiplier and a radix-2 restoring divider, with a valid/ready request handshake and a one-cycle response pulse. It adds zero-latency corner-case paths, flush abort, and a quotient/remainder cache so that a DIV followed by a REM on the same operands returns in one cycle.

Parameters:
XLEN, 32, operand/result width; must be 32 or 64.
MUL_STEP, 4, multiplier bits retired per cycle; must divide XLEN (1, 2, 4, 8).

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
flush  input  1  abort any in-flight operation
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_funct  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
req_rs1  input  XLEN  operand a (dividend / multiplicand)
req_rs2  input  XLEN  operand b (divisor / multiplier)
resp_valid  output  1  one-cycle pulse, result valid
resp_data  output  XLEN  result
busy  output  1  operation in flight (state != IDLE)

Behaviour:
- Reset: state IDLE, req_ready=1, resp_valid=0, resp_data=0, busy=0, cache invalid.
- Acceptance: request accepted on a rising edge where req_valid && req_ready && !flush (cycle T). req_ready = (state==IDLE), independent of req_valid. Operands are latched at acceptance and ignored afterwards.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE -> DONE on a fast-path request.
  - IDLE -> MUL on funct 0-3.
  - IDLE -> DIV on funct 4-7.
  - MUL/DIV -> DONE after the final iteration.
  - DONE -> IDLE unconditionally.
  - resp_valid=1 only in DONE. There is no backpressure; the consumer must take the result.
- Latency (resp_valid high in cycle):
  - fast path: T+1
  - MUL family: T+XLEN/MUL_STEP+1
  - DIV family: T+XLEN+1
- Fast paths (no iteration):
  - divide by zero: DIV/DIVU return all ones; REM/REMU return rs1.
  - signed overflow (DIV with rs1 = most-negative, rs2 = -1): DIV returns rs1; REM returns 0.
  - cache hit (see below).
- Multiply: operands are converted to magnitudes per funct signedness (MULH both signed, MULHSU rs1 signed / rs2 unsigned, MULHU/MUL unsigned-equivalent). The 2*XLEN product accumulates MUL_STEP bits per cycle and is conditionally negated at the end. MUL returns product[XLEN-1:0]; the others return product[2*XLEN-1:XLEN]. The result must equal the exact mathematical product.
- Divide: DIV/REM use magnitudes. The radix-2 restoring divider runs one quotient bit per cycle for XLEN cycles. The quotient is negated if the operand signs differ; the remainder takes the sign of the dividend. Truncating division per RV spec.
- Cache:
  - Tagged by {rs1, rs2, signed}. Written with both quotient and remainder on every divide completion, including the div-by-zero and overflow fast paths.
  - A later DIV/REM (or DIVU/REMU) with matching tag hits and returns at T+1.
  - Invalidated by rst only; flush does not invalidate completed entries.
  - MUL ops neither read nor modify the cache.
- Flush:
  - flush high in any cycle forces state to IDLE on that edge and suppresses resp_valid; a flush in DONE kills that pulse.
  - An aborted op does not update the cache.
  - A request presented with flush is not accepted.
  - req_ready is 1 the cycle after a flush.
- rst has priority over flush; both have priority over acceptance.

Test Plan:
- MUL 7 x 0xFFFFFFF9 (-7) with XLEN=32, MUL_STEP=4 -> resp_data 0xFFFFFFCF at T+9. MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD at T+33; then REM with the same operands -> 0xFFFFFFFF at T+1 (cache hit); then REMU with the same operands -> full T+33 latency, result 1.
- DIVU 5 / 0 -> 0xFFFFFFFF at T+1; REMU 5 / 0 -> 5 at T+1. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- DIV in flight, flush asserted at iteration 10 -> resp_valid never rises, req_ready=1 next cycle. A following REM with the same operands misses the cache and takes T+33.
- rst asserted mid-MUL -> next cycle outputs at reset values. The same-operand DIV/REM pair re-executes at full latency (cache cleared).
- Back-to-back requests with req_valid held high: the second request is accepted only in the cycle after DONE. Random signed/unsigned sweep vs golden model, all 8 functs, with XLEN=64 and MUL_STEP in {1, 8}.
